// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin grant arbiter.
// Optional feature macro: ARB_TIMEOUT_EN (see rr_grant_arbiter.sv).
package arb_pkg;

  localparam int unsigned DEFAULT_NUM_REQ = 4;
  localparam int unsigned DEFAULT_TIMEOUT = 16;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_e;

  // Width of an owner index for n requesters (never below one bit).
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational highest-index-first pick over a request vector masked to the
// indices strictly below last_id, falling back to the whole vector when the
// masked set is empty. Requesters in i_excl never win.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  localparam int unsigned IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_last_id,
  input  logic [NUM_REQ-1:0] i_excl,
  output logic [IDW-1:0]     o_winner,
  output logic               o_any
);

  logic [NUM_REQ-1:0] w_below;
  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_masked;
  logic [NUM_REQ-1:0] w_sel;

  // Build the rotation mask and choose between masked and full candidate sets.
  always_comb begin
    w_below = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) < i_last_id) w_below[i] = 1'b1;
    end
    w_cand   = i_req & ~i_excl;
    w_masked = w_cand & w_below;
    w_sel    = (|w_masked) ? w_masked : w_cand;
    o_any    = |w_cand;
  end

  // Priority encode: ascending scan so the highest set index wins.
  always_comb begin
    o_winner = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_sel[i]) o_winner = IDW'(i);
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with grant-hold. The grant is registered and stays with
// its owner until the owner drops its request; on release the next winner is
// granted directly with no idle cycle.
// Optional feature macro: ARB_TIMEOUT_EN -- when defined, an owner holding the
// grant for TIMEOUT cycles is pre-empted if any other requester is waiting.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  parameter  int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  localparam int unsigned IDW     = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id,
  output logic               gnt_valid
);

  if (NUM_REQ < 2 || TIMEOUT < 2) begin : g_bad_cfg
    $error("rr_grant_arbiter: NUM_REQ and TIMEOUT must both be >= 2");
  end

  arb_state_e         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IDW-1:0]     r_gnt_id;
  logic               r_valid;
  logic [IDW-1:0]     r_last_id;

  logic               w_owner_req;
  logic               w_preempt;
  logic [NUM_REQ-1:0] w_excl;
  logic [IDW-1:0]     w_winner;
  logic               w_any;
  logic [NUM_REQ-1:0] w_win_1h;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Pre-emption is only considered once the owner has used its full slot.
  always_comb begin
    w_preempt = (r_state == GRANT) && w_owner_req && (r_cnt == CNT_MAX);
  end
`else
  // Without the timeout the owner is never pre-empted.
  always_comb begin
    w_preempt = 1'b0;
  end
`endif

  // Owner status and exclusion mask feeding the pick.
  always_comb begin
    w_owner_req = |(req & r_gnt);
    w_excl      = w_preempt ? r_gnt : '0;
    w_win_1h    = NUM_REQ'(1) << w_winner;
  end

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .i_req    (req),
    .i_last_id(r_last_id),
    .i_excl   (w_excl),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // Grant FSM: idle/grant state, registered outputs and rotation pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_valid   <= 1'b0;
      r_last_id <= '0;
`ifdef ARB_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state   <= GRANT;
            r_gnt     <= w_win_1h;
            r_gnt_id  <= w_winner;
            r_valid   <= 1'b1;
            r_last_id <= w_winner;
`ifdef ARB_TIMEOUT_EN
            r_cnt     <= '0;
`endif
          end
        end
        GRANT: begin
          // Owner still requesting: hold, unless its slot expired and someone
          // else is waiting (w_any already excludes the owner in that case).
          if (w_owner_req && !(w_preempt && w_any)) begin
`ifdef ARB_TIMEOUT_EN
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
`endif
          end else if (w_any) begin
            r_gnt     <= w_win_1h;
            r_gnt_id  <= w_winner;
            r_valid   <= 1'b1;
            r_last_id <= w_winner;
`ifdef ARB_TIMEOUT_EN
            r_cnt     <= '0;
`endif
          end else begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_valid  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_cnt    <= '0;
`endif
          end
        end
        default: begin
          r_state  <= IDLE;
          r_gnt    <= '0;
          r_gnt_id <= '0;
          r_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_valid;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: a behavioural owner/pointer model
// compared every cycle, plus directed vectors with literal expectations.
// Build with or without +define+ARB_TIMEOUT_EN; TIMEOUT is set to 4.
module tb_rr_grant_arbiter;

  localparam int N  = 4;
  localparam int TO = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req   = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;

  int n_checks = 0;
  int n_fail   = 0;

  rr_grant_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_owner = -1;
  int m_last  = 0;
  int m_cnt   = 0;

  // Rotating pick: highest requester below last, else highest overall.
  function automatic int pick(input logic [3:0] r, input int last, input int excl);
    for (int i = N - 1; i >= 0; i--) if (r[i] && i != excl && i < last) return i;
    for (int i = N - 1; i >= 0; i--) if (r[i] && i != excl) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int w;
    logic [3:0] own;
    if (!rst_n) begin
      m_owner = -1;
      m_last  = 0;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      if (req != 0) begin
        w = pick(req, m_last, -1);
        m_owner = w; m_last = w; m_cnt = 0;
      end
    end else if (req[m_owner]) begin
      own = 4'b0001 << m_owner;
      if (TO_EN && m_cnt == TO - 1 && (req & ~own) != 0) begin
        w = pick(req, m_last, m_owner);
        m_owner = w; m_last = w; m_cnt = 0;
      end else if (TO_EN && m_cnt < TO - 1) begin
        m_cnt++;
      end
    end else if (req != 0) begin
      w = pick(req, m_last, -1);
      m_owner = w; m_last = w; m_cnt = 0;
    end else begin
      m_owner = -1;
      m_cnt   = 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [3:0] e_gnt;
    e_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    check("model_gnt",    gnt,       e_gnt);
    check("model_gnt_id", gnt_id,    (m_owner < 0) ? 0 : m_owner);
    check("model_valid",  gnt_valid, (m_owner < 0) ? 0 : 1);
    check("onehot0",      $onehot0(gnt), 1);
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_owner(input string name, input int id);
    logic [3:0] e;
    e = 4'b0001 << id;
    check({name, "_gnt"}, gnt, e);
    check({name, "_id"}, gnt_id, id);
    check({name, "_valid"}, gnt_valid, 1);
  endtask

  task automatic expect_idle(input string name);
    check({name, "_gnt"}, gnt, 0);
    check({name, "_id"}, gnt_id, 0);
    check({name, "_valid"}, gnt_valid, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    #1;
    expect_idle("reset");

    // Highest request wins from reset; grant held while owner requests.
    do_reset();
    step(4'b0101);
    expect_owner("first", 2);
    for (int i = 1; i <= 10; i++) begin
      step(4'b0101);
      expect_owner("hold2", TO_EN ? (((i / TO) % 2 == 0) ? 2 : 0) : 2);
    end

    // Rotation 3,2,1,0,3 with each owner releasing for one cycle.
    do_reset();
    step(4'b1111); expect_owner("rot0", 3);
    step(4'b0111); expect_owner("rot1", 2);
    step(4'b1011); expect_owner("rot2", 1);
    step(4'b1101); expect_owner("rot3", 0);
    step(4'b1110); expect_owner("rot4", 3);

    // Release to idle, then re-grant one cycle later.
    do_reset();
    step(4'b0010); expect_owner("solo", 1);
    step(4'b0000); expect_idle("release");
    step(4'b0010); expect_owner("regrant", 1);

    // Asynchronous reset between edges clears outputs immediately.
    #3 rst_n = 1'b0;
    #1 expect_idle("async_rst");
    #2 begin rst_n = 1'b1; req = 4'b1000; end
    step(4'b1000); expect_owner("post_rst", 3);

    // Two contenders held: alternate on timeout, otherwise owner 1 keeps it.
    do_reset();
    step(4'b0011); expect_owner("to_first", 1);
    for (int i = 1; i < 100; i++) begin
      step(4'b0011);
      expect_owner("to_hold", TO_EN ? (((i / TO) % 2 == 0) ? 1 : 0) : 1);
    end

    // Lone requester is never pre-empted.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      step(4'b0010);
      expect_owner("lone", 1);
    end

    step(4'b0000); expect_idle("final");
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter with grant-hold, for sharing one resource between NUM_REQ requesters.
- Internally uses a highest-index-first priority pick over a masked request vector.
- The grant is registered and stays with its owner until that owner drops its request.
- Sits in front of shared datapath resources: bus port, memory bank, shared ALU.

Parameters:
NUM_REQ, 4, number of requesters; must be >= 2
TIMEOUT, 16, maximum hold cycles when ARB_TIMEOUT_EN is defined; must be >= 2

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
req  in  NUM_REQ  request vector; bit i is requester i
gnt  out  NUM_REQ  one-hot grant, registered
gnt_id  out  $clog2(NUM_REQ)  index of the current owner; 0 when gnt_valid=0
gnt_valid  out  1  high while any grant is held

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: gnt=0, gnt_id=0, gnt_valid=0, state=IDLE, last_id=0, hold counter=0.
- Reset taking effect mid-grant: outputs clear immediately, without waiting for a clock edge.

Pick function (combinational):
- masked = req & (bits strictly below last_id).
- If masked != 0, the winner is the highest set index in masked.
- Otherwise the winner is the highest set index in req.
- With last_id=0 the mask is empty, so the highest request wins overall.

States:
- IDLE:
  - If req != 0, the next state is GRANT: gnt=onehot(winner), gnt_id=winner, last_id=winner.
  - Latency is 1 cycle from req to gnt.
- GRANT, owner o:
  - While req[o]=1, the grant is held unchanged. Other requests are ignored, and the grant never moves while it is held.
  - If req[o]=0 and others are requesting, the next cycle grants the new winner directly, with no idle cycle. req[o]=0 excludes o naturally.
  - If req[o]=0 and req==0, the next state is IDLE with all outputs cleared.
- Fairness: each release advances last_id. A requester held continuously waits at most NUM_REQ-1 grants.
- Simultaneous events:
  - A new request arriving in the same cycle as the owner's release takes part in that cycle's pick.
  - An owner that drops req and reasserts it in the next cycle re-arbitrates against last_id. It does not get an immediate repeat grant if others are waiting.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_valid == |gnt.
  - gnt_id == the index of the set bit in gnt.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter increments each GRANT cycle and clears on every new grant.
  - When the counter reaches TIMEOUT-1 and (req & ~onehot(o)) != 0, the next cycle grants the pick with o masked out, even though req[o]=1. last_id advances.
  - If no other requester is active, the grant is held and the counter saturates at TIMEOUT-1.
- Undefined: there is no counter, and the grant is held for as long as the owner requests.

Decomposition:
- Package arb_pkg holds:
  - localparam helpers for the id width, $clog2(NUM_REQ).
  - typedef enum logic {IDLE, GRANT} arb_state_e.
  - The default TIMEOUT constant.
- Sub-module rr_pick: the combinational masked highest-index pick.
  - Inputs: req, last_id, exclude-mask.
  - Outputs: winner, any.
- The top level holds the FSM, registers and counter.

Test Plan:
- Reset then req=4'b0101: gnt=4'b0100 and gnt_id=2 one cycle later; gnt holds while req[2]=1 for 10 cycles.
- req=4'b1111 held; each owner drops req for one cycle after being granted, then reasserts: grant order 3,2,1,0,3, with no idle cycle between grants.
- Owner 1 drops with req=0 elsewhere: gnt=0 and gnt_valid=0 next cycle. Then req=4'b0010 again: re-granted 1 cycle later.
- rst_n pulsed low mid-grant, asynchronously between clock edges: gnt=0, gnt_id=0, gnt_valid=0 immediately. After release with req=4'b1000: gnt=4'b1000.
- Build with ARB_TIMEOUT_EN and TIMEOUT=4, req=4'b0011 held: owner 1 for 4 cycles, then owner 0 for 4 cycles, then owner 1. With req=4'b0010 only, owner 1 is held indefinitely.
- Build without ARB_TIMEOUT_EN, same stimulus: owner 1 is held for 100 cycles with no switch.
